// File: rtl/k_wput_arb_t1.sv
// Round-robin arbiter sharing one FIFO write port among 2**id_size requesters.
// Data and handshake pass through combinationally; only grant state is registered.
module k_wput_arb_t1 #(
  parameter int unsigned data_size = 8,
  parameter int unsigned id_size   = 2,
  parameter int unsigned max_burst = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [(2**id_size)-1:0]             req_put,
  input  logic [(2**id_size)*data_size-1:0]   req_data,
  output logic [(2**id_size)-1:0]             req_rdy,
  output logic [data_size-1:0]                wdata,
  output logic                                wput,
  input  logic                                wrdy,
  output logic                                gnt_vld,
  output logic [id_size-1:0]                  gnt_id,
  output logic [7:0]                          burst_cnt
);

  localparam int unsigned NReq = 2 ** id_size;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [id_size-1:0] gnt_id_q, gnt_id_d;
  logic [id_size-1:0] last_id_q, last_id_d;
  logic [7:0]         burst_q, burst_d;

  logic               xfer;
  logic               rel;
  logic               found;
  logic [id_size-1:0] base;
  logic [id_size-1:0] idx;
  logic [id_size-1:0] win;

  // Owner-side datapath; reset masks the handshake so no word moves in a reset cycle.
  always_comb begin
    wput    = 1'b0;
    req_rdy = '0;
    wdata   = req_data[0 +: data_size];
    if (state_q == StGrant) begin
      wdata = req_data[gnt_id_q*data_size +: data_size];
      if (!rst) begin
        wput              = req_put[gnt_id_q];
        req_rdy[gnt_id_q] = wrdy;
      end
    end
  end

  assign xfer = wput && wrdy;
  assign rel  = (state_q == StGrant) &&
                (!req_put[gnt_id_q] || (xfer && (burst_q == 8'(max_burst - 1))));

  // Search starts just after base and ends on base itself, so base is lowest priority.
  always_comb begin
    base  = (state_q == StGrant) ? gnt_id_q : last_id_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NReq; k++) begin
      idx = base + id_size'(k);
      if (!found && req_put[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    burst_d   = burst_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StGrant;
          gnt_id_d = win;
          burst_d  = '0;
        end
      end
      StGrant: begin
        if (rel) begin
          last_id_d = gnt_id_q;
          burst_d   = '0;
          if (found) begin
            gnt_id_d = win;
          end else begin
            state_d = StIdle;
          end
        end else if (xfer) begin
          burst_d = burst_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_id_q  <= '0;
      last_id_q <= id_size'(NReq - 1);
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      burst_q   <= burst_d;
    end
  end

  assign gnt_vld   = (state_q == StGrant);
  assign gnt_id    = gnt_id_q;
  assign burst_cnt = burst_q;

endmodule

// File: tb/tb_k_wput_arb_t1.sv
// Bench for k_wput_arb_t1: directed vector table, hand-written sequences,
// then random stimulus against a rule-level reference model.
module tb_k_wput_arb_t1;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_put;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic [DW-1:0]   wdata;
  logic            wput;
  logic            wrdy;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_id;
  logic [7:0]      burst_cnt;

  k_wput_arb_t1 #(.data_size(DW), .id_size(IW), .max_burst(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_put  (req_put),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .wdata    (wdata),
    .wput     (wput),
    .wrdy     (wrdy),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // Reference model state: grant held, owner, words in grant, previous owner.
  bit m_vld;
  int m_id, m_cnt, m_last;

  typedef struct {
    bit       r;
    bit [3:0] put;
    bit       rdy;
    bit       e_vld;
    int       e_id;
    int       e_cnt;
    bit       e_wput;
    bit [3:0] e_rdy;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int base, input logic [N-1:0] p);
    for (int k = 1; k <= int'(N); k++) begin
      if (p[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    bit x;
    if (rst) begin
      m_vld = 0; m_id = 0; m_cnt = 0; m_last = N - 1;
    end else if (!m_vld) begin
      w = pick(m_last, req_put);
      if (w >= 0) begin
        m_vld = 1; m_id = w; m_cnt = 0;
      end
    end else begin
      x = req_put[m_id] && wrdy;
      if (!req_put[m_id] || (x && m_cnt + 1 == int'(MB))) begin
        m_last = m_id;
        m_cnt  = 0;
        w = pick(m_id, req_put);
        if (w >= 0) m_id = w;
        else m_vld = 0;
      end else if (x) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model();
    bit       ew;
    bit [3:0] er;
    ew = !rst && m_vld && req_put[m_id];
    er = (!rst && m_vld) ? (4'(wrdy) << m_id) : 4'b0000;
    chk("rnd_gnt_vld", 32'(gnt_vld), 32'(m_vld));
    if (m_vld) chk("rnd_gnt_id", 32'(gnt_id), 32'(m_id));
    chk("rnd_burst_cnt", 32'(burst_cnt), 32'(m_cnt));
    chk("rnd_wput", 32'(wput), 32'(ew));
    chk("rnd_req_rdy", 32'(req_rdy), 32'(er));
    if (ew) chk("rnd_wdata", 32'(wdata), 32'(req_data[m_id*DW +: DW]));
  endtask

  initial begin
    int n, bub;
    tbl[0]  = '{1, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{1, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
    tbl[2]  = '{0, 4'b1111, 1, 0, 0, 0, 0, 4'b0000};
    tbl[3]  = '{0, 4'b1111, 1, 1, 0, 0, 1, 4'b0001};
    tbl[4]  = '{0, 4'b1111, 1, 1, 0, 1, 1, 4'b0001};
    tbl[5]  = '{0, 4'b1111, 1, 1, 0, 2, 1, 4'b0001};
    tbl[6]  = '{0, 4'b1111, 1, 1, 0, 3, 1, 4'b0001};
    tbl[7]  = '{0, 4'b1111, 1, 1, 1, 0, 1, 4'b0010};
    tbl[8]  = '{0, 4'b1111, 1, 1, 1, 1, 1, 4'b0010};
    for (int i = 9; i <= 13; i++) tbl[i] = '{0, 4'b1111, 0, 1, 1, 2, 1, 4'b0000};
    tbl[14] = '{0, 4'b1111, 1, 1, 1, 2, 1, 4'b0010};
    tbl[15] = '{0, 4'b1111, 1, 1, 1, 3, 1, 4'b0010};
    tbl[16] = '{0, 4'b1000, 1, 1, 2, 0, 0, 4'b0100};
    tbl[17] = '{0, 4'b1001, 1, 1, 3, 0, 1, 4'b1000};
    tbl[18] = '{0, 4'b0001, 1, 1, 3, 1, 0, 4'b1000};
    tbl[19] = '{0, 4'b0001, 1, 1, 0, 0, 1, 4'b0001};
    tbl[20] = '{0, 4'b0000, 1, 1, 0, 1, 0, 4'b0001};
    tbl[21] = '{0, 4'b0100, 1, 0, 0, 0, 0, 4'b0000};
    tbl[22] = '{0, 4'b0100, 1, 1, 2, 0, 1, 4'b0100};
    tbl[23] = '{1, 4'b0100, 1, 1, 2, 1, 0, 4'b0000};
    tbl[24] = '{0, 4'b0011, 1, 0, 0, 0, 0, 4'b0000};
    tbl[25] = '{0, 4'b0011, 1, 1, 0, 0, 1, 4'b0001};

    rst = 1; req_put = '0; wrdy = 0; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; req_put = tbl[i].put; wrdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_gnt_vld", i), 32'(gnt_vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_gnt_id", i), 32'(gnt_id), 32'(tbl[i].e_id));
      chk($sformatf("tbl%0d_burst_cnt", i), 32'(burst_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_wput", i), 32'(wput), 32'(tbl[i].e_wput));
      chk($sformatf("tbl%0d_req_rdy", i), 32'(req_rdy), 32'(tbl[i].e_rdy));
      if (tbl[i].e_wput) chk($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'hA0 + 32'(tbl[i].e_id));
      @(posedge clk);
    end

    // Single requester: ten words, bursts re-granted to 2 back to back.
    @(negedge clk); rst = 1; req_put = '0;
    @(posedge clk);
    n = 0; bub = 0;
    for (int c = 0; c < 30 && n < 10; c++) begin
      @(negedge clk);
      rst = 0; req_put = 4'b0100; wrdy = 1;
      req_data = '0; req_data[2*DW +: DW] = 8'(8'h10 + n);
      #1;
      if (wput && wrdy) begin
        chk("single_wdata", 32'(wdata), 32'(8'h10 + n));
        chk("single_gnt_id", 32'(gnt_id), 32'd2);
        n++;
      end else if (n > 0) begin
        bub++;
      end
      @(posedge clk);
    end
    chk("single_words", 32'(n), 32'd10);
    chk("single_bubbles", 32'(bub), 32'd0);

    // Random stimulus against the reference model.
    @(negedge clk); rst = 1; req_put = '0;
    @(posedge clk); model_edge();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(63) == 0);
      req_put  = 4'($urandom);
      wrdy     = ($urandom_range(3) != 0);
      req_data = 32'($urandom);
      #1;
      check_model();
      @(posedge clk);
      model_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
